// File: rtl/y86_execute_ctrl.sv
// Y86-64 execute-stage sequencer: drives the shared ALU, captures valE,
// maintains {ZF,SF,OF} and evaluates Cnd for jXX/cmovXX.
module y86_execute_ctrl #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned STACK_STEP = 8,
  parameter logic [2:0]  CC_RESET   = 3'b100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fn,
  input  logic [WIDTH-1:0] alu_valE,
  input  logic             alu_car,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_valE,
  output logic             out_cnd,
  output logic             out_err,
  output logic [2:0]       cc_out
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t     state;
  logic [3:0] icode_q;
  logic [3:0] ifun_q;
  logic [2:0] cc;

  logic       cnd;
  logic       err;
  logic       is_op;
  logic       is_cond;
  logic       new_zf;
  logic       new_sf;
  logic       new_of;
  logic       unused_car;

  // No Y86 flag is derived from the ALU carry.
  assign unused_car = alu_car;
  assign cc_out     = cc;

  // Decode the latched instruction: condition, legality and next flags.
  always_comb begin
    cnd     = 1'b0;
    err     = 1'b0;
    new_of  = 1'b0;
    is_op   = (icode_q == 4'h6);
    is_cond = (icode_q == 4'h2) || (icode_q == 4'h7);
    new_zf  = (alu_valE == '0);
    new_sf  = alu_valE[WIDTH-1];

    case (ifun_q)
      4'h0:    cnd = 1'b1;
      4'h1:    cnd = (cc[1] ^ cc[0]) | cc[2];
      4'h2:    cnd = cc[1] ^ cc[0];
      4'h3:    cnd = cc[2];
      4'h4:    cnd = ~cc[2];
      4'h5:    cnd = ~(cc[1] ^ cc[0]);
      4'h6:    cnd = ~(cc[1] ^ cc[0]) & ~cc[2];
      default: cnd = 1'b0;
    endcase

    if (icode_q > 4'hB)  err = 1'b1;
    else if (is_op)      err = (ifun_q > 4'h3);
    else if (is_cond)    err = (ifun_q > 4'h6);
    else                 err = (ifun_q != 4'h0);

    // Signed overflow uses the operand signs held in the ALU operand registers.
    case (ifun_q)
      4'h0: new_of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                     (alu_valE[WIDTH-1] != alu_a[WIDTH-1]);
      4'h1: new_of = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                     (alu_valE[WIDTH-1] != alu_a[WIDTH-1]);
      default: new_of = 1'b0;
    endcase
  end

  // Sequencer: accept, execute one cycle, hold result until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      icode_q   <= 4'h0;
      ifun_q    <= 4'h0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fn    <= 4'h0;
      out_valid <= 1'b0;
      out_valE  <= '0;
      out_cnd   <= 1'b0;
      out_err   <= 1'b0;
      cc        <= CC_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            icode_q  <= icode;
            ifun_q   <= ifun;
            in_ready <= 1'b0;
            state    <= EXEC;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_fn   <= 4'h0;
            case (icode)
              4'h6: begin alu_a <= valB; alu_b <= valA; alu_fn <= ifun; end
              4'h2: begin alu_a <= valA; end
              4'h3: begin alu_a <= valC; end
              4'h4, 4'h5: begin alu_a <= valC; alu_b <= valB; end
              4'h8, 4'hA: begin
                alu_a  <= valB;
                alu_b  <= WIDTH'(STACK_STEP);
                alu_fn <= 4'h1;
              end
              4'h9, 4'hB: begin
                alu_a  <= valB;
                alu_b  <= WIDTH'(STACK_STEP);
              end
              default: ;
            endcase
          end
        end
        EXEC: begin
          out_valE  <= err ? '0 : alu_valE;
          out_cnd   <= ~err & is_cond & cnd;
          out_err   <= err;
          out_valid <= 1'b1;
          state     <= HOLD;
          if (is_op && !err) cc <= {new_zf, new_sf, new_of};
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/y86_execute_ctrl.md
Name: y86_execute_ctrl

Overview:
Execute-stage sequencer for the Y86-64 core.
- Accepts one decoded instruction per valid/ready handshake.
- Selects and drives the shared ALU operands and function code, captures the ALU result, maintains the condition-code register (ZF, SF, OF), and evaluates the branch/move condition Cnd.
- Sits between decode and memory stages; it is the only master of the ALU ports.

Parameters:
WIDTH, 64, datapath width of valA/valB/valC/valE.
STACK_STEP, 8, byte adjustment for call/push (subtract) and ret/pop (add).
CC_RESET, 3'b100, reset value of {ZF,SF,OF}.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  decode presents an instruction
in_ready  out  1  controller can accept; high only in IDLE
icode  in  4  Y86 instruction code
ifun  in  4  Y86 function code
valA  in  WIDTH  rA operand
valB  in  WIDTH  rB operand
valC  in  WIDTH  immediate/displacement
alu_a  out  WIDTH  ALU operand A (registered)
alu_b  out  WIDTH  ALU operand B (registered)
alu_fn  out  4  ALU function: 0 add (A+B), 1 sub (A-B), 2 and, 3 xor
alu_valE  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_fn
alu_car  in  1  ALU carry; ignored, no Y86 flag uses it
out_valid  out  1  result valid toward memory stage
out_ready  in  1  memory stage accepts
out_valE  out  WIDTH  registered execute result
out_cnd  out  1  condition result for jXX/cmovXX; 0 otherwise
out_err  out  1  illegal icode/ifun combination
cc_out  out  3  current {ZF,SF,OF}

Behaviour:
- Reset: state IDLE; alu_a=0, alu_b=0, alu_fn=0; out_valid=0, out_valE=0, out_cnd=0, out_err=0; cc=CC_RESET. Reset mid-transaction discards the instruction; no CC update.
- States: IDLE -> EXEC on in_valid&in_ready. EXEC -> HOLD unconditionally after one cycle. HOLD -> IDLE when out_ready.
- Accept (IDLE edge): load alu_a/alu_b/alu_fn and latch icode/ifun and operand signs.
  - OPq (6): a=valB, b=valA, fn=ifun, so subq yields rB-rA.
  - rrmovq/cmovXX (2): a=valA, b=0, fn=0.
  - irmovq (3): a=valC, b=0, fn=0.
  - rmmovq/mrmovq (4,5): a=valC, b=valB, fn=0.
  - call/pushq (8,A): a=valB, b=STACK_STEP, fn=1.
  - ret/popq (9,B): a=valB, b=STACK_STEP, fn=0.
  - halt/nop/jXX (0,1,7): a=0, b=0, fn=0.
- EXEC edge:
  - out_valE <= alu_valE.
  - out_cnd from pre-update CC for icode 2/7, else 0.
  - out_err computed.
  - For OPq without error: ZF=(valE==0); SF=valE[WIDTH-1]; OF for add is (a_msb==b_msb)&(r_msb!=a_msb), for sub (a_msb!=b_msb)&(r_msb!=a_msb), for and/xor 0.
- Cnd by ifun:
  - 0: 1
  - 1: (SF^OF)|ZF
  - 2: SF^OF
  - 3: ZF
  - 4: !ZF
  - 5: !(SF^OF)
  - 6: !(SF^OF)&!ZF
- Errors:
  - out_err=1 for icode>0xB, OPq ifun>3, icode 2/7 ifun>6, or other icode with ifun!=0.
  - On error: out_valE=0, out_cnd=0, CC unchanged.
- HOLD: out_valid=1; outputs stable until out_ready. Drop out_valid on the accepting edge. in_ready stays 0.
- Timing: latency is accept edge N to out_valid at N+2. Minimum occupancy is 3 cycles per instruction.
- in_valid outside IDLE is ignored; decode holds its inputs until in_ready.

Test Plan:
- Reset, then OPq addq: valA=5, valB=7 -> out_valE=12, cc=000, out_valid two cycles after accept.
- OPq subq: valA=1, valB=1 -> out_valE=0, cc=100. Then jXX ifun=3 (je) -> out_cnd=1, cc unchanged.
- OPq addq: valA=valB=64'h7FFF_FFFF_FFFF_FFFF -> out_valE=64'hFFFF_FFFF_FFFF_FFFE, cc=011. Then jXX ifun=2 (jl) -> cnd=0; ifun=6 (jg) -> cnd=1.
- pushq valB=0x100 -> alu_fn=1, out_valE=0xF8. popq valB=0xF8 -> out_valE=0x100. CC unchanged in both.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid, out_valE stable and in_ready=0. Release -> IDLE next cycle.
- OPq ifun=7 -> out_err=1, out_valE=0, CC unchanged. Reset asserted during EXEC -> out_valid=0, cc=100 immediately.
